// File: rtl/cla_pkg.sv
// Shared definitions for the CLA nibble sequencer.
// Holds state encoding, nibble width and the nibble-count helper.
package cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer.sv
// Feeds a 4-bit CLA one nibble per cycle, LSB first, chaining carry.
// Optional subtract: define CLA_NIBBLE_SEQUENCER_SUB_EN to add in_sub.
module cla_nibble_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
  input  logic             in_sub,
`endif
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b,
  output logic             nib_cin,
  input  logic [3:0]       nib_s,
  input  logic [4:0]       nib_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 4");
  end

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  int               base;

  // Carry bits below bit 3 are not needed here.
  logic unused_nib_c;
  assign unused_nib_c = ^nib_c[2:0];

  assign base = NIB_W * int'(idx_q);

  // Next-state, nibble drive and result assembly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    nib_a   = '0;
    nib_b   = '0;
    nib_cin = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
          b_d     = in_sub ? ~in_b : in_b;
          cin_d   = in_sub ? 1'b1 : in_cin;
`else
          b_d     = in_b;
          cin_d   = in_cin;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        nib_a   = a_q[base +: NIB_W];
        nib_b   = b_q[base +: NIB_W];
        nib_cin = (idx_q == '0) ? cin_q : carry_q;
        sum_d[base +: NIB_W] = nib_s;
        carry_d = nib_c[4];
        if (idx_q == IDX_LAST) begin
          cout_d  = nib_c[4];
          ovf_d   = nib_c[4] ^ nib_c[3];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Scoreboard bench for cla_nibble_sequencer with a 4-bit adder model.
// Directed vectors; expected results are hand-computed constants.
module tb_cla_nibble_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic         in_sub;
  logic [3:0]   nib_a, nib_b, nib_s;
  logic         nib_cin;
  logic [4:0]   nib_c;
  logic         out_valid, out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_nibble_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
    .in_sub(in_sub),
`endif
    .nib_a(nib_a), .nib_b(nib_b), .nib_cin(nib_cin),
    .nib_s(nib_s), .nib_c(nib_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // Behavioural 4-bit carry-lookahead adder stage.
  always_comb begin
    nib_c    = '0;
    nib_s    = '0;
    nib_c[0] = nib_cin;
    for (int i = 0; i < 4; i++) begin
      nib_s[i]   = nib_a[i] ^ nib_b[i] ^ nib_c[i];
      nib_c[i+1] = (nib_a[i] & nib_b[i]) | ((nib_a[i] ^ nib_b[i]) & nib_c[i]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency on rising out_valid, result compare on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_valid)
      chk("latency", 32'(cyc - acc_cyc), 32'd4);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_cout", 32'(out_cout), 32'(e.cout));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
    prev_valid <= out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input logic push, input exp_t e);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    acc_cyc = cyc + 1;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    step();
  endtask

  initial begin
    exp_t held;
    logic [3:0] cin_seq;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    in_sub = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_nib_a", 32'(nib_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    issue(16'h1234, 16'h0FED, 1'b0, 1'b0, 1'b1, '{16'h2221, 1'b0, 1'b0});
    @(negedge clk);
    chk("run0_nib_a", 32'(nib_a), 32'h4);
    chk("run0_nib_b", 32'(nib_b), 32'hD);
    drain();

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cin_seq[k] = nib_cin;
    end
    chk("ripple_nib_cin", 32'(cin_seq), 32'b1110);
    drain();

    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'h8000, 1'b0, 1'b1});
    drain();

    issue(16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b1, '{16'h1001, 1'b0, 1'b0});
    drain();

    out_ready = 1'b0;
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b1});
    for (int k = 0; k < 6; k++) step();
    held = '{out_sum, out_cout, out_ovf};
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_a = 16'h1111;
    in_b = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_sum_stable", 32'(out_sum), 32'(held.sum));
      chk("bp_flags_stable", 32'({out_cout, out_ovf}), 32'({held.cout, held.ovf}));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    step();

    issue(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0, '0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_sum", 32'(out_sum), 32'd0);
    step();
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'h0002, 1'b0, 1'b0});
    drain();

`ifdef CLA_NIBBLE_SEQUENCER_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    drain();
    issue(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, '{16'h0002, 1'b1, 1'b0});
    drain();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
    drain();
`endif

    for (int k = 0; k < 8; k++) step();
    chk("no_stray_valid", 32'(out_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
